// File: rtl/scariv_conf_pkg.sv
// Core-wide configuration constants shared by the dispatch and issue logic.
package scariv_conf_pkg;

    localparam int NUM_BRU_UNITS  = 2;
    localparam int BRU_DISP_SIZE  = 2;
    localparam int BRU_ENTRY_SIZE = 32;

endpackage : scariv_conf_pkg

// File: rtl/scariv_pkg.sv
// Shared types for the branch dispatch credit arbiter.
package scariv_pkg;

    localparam int NUM_BRU_UNITS  = scariv_conf_pkg::NUM_BRU_UNITS;
    localparam int BRU_DISP_SIZE  = scariv_conf_pkg::BRU_DISP_SIZE;
    localparam int BRU_ENTRY_SIZE = scariv_conf_pkg::BRU_ENTRY_SIZE;
    localparam int BRU_ARB_CW     = $clog2(BRU_ENTRY_SIZE) + 1;

    typedef logic [BRU_ARB_CW-1:0] bru_arb_credit_t;

endpackage : scariv_pkg

// File: rtl/scariv_bru_arb_slot_map.sv
// Steers the k-th valid dispatch slot to unit (rr_ptr + k) mod NUM_UNITS and
// reports how many slots land on each unit.
module scariv_bru_arb_slot_map
    import scariv_pkg::*;
#(
    parameter int NUM_UNITS    = NUM_BRU_UNITS,
    parameter int IN_PORT_SIZE = BRU_DISP_SIZE,
    parameter int PW           = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int DW           = $clog2(IN_PORT_SIZE + 1)
) (
    input  logic [PW-1:0]                     i_rr_ptr,
    input  logic [IN_PORT_SIZE-1:0]           i_req,
    output logic [NUM_UNITS*IN_PORT_SIZE-1:0] o_slot_map,
    output logic [NUM_UNITS*DW-1:0]           o_demand,
    output logic [DW-1:0]                     o_req_cnt
);

    int            tgt;
    logic [DW-1:0] prefix;

    // prefix counts the valid slots below k, giving each slot its round-robin offset
    always_comb begin
        o_slot_map = '0;
        o_demand   = '0;
        prefix     = '0;
        tgt        = 0;
        for (int k = 0; k < IN_PORT_SIZE; k++) begin
            if (i_req[k]) begin
                tgt = (int'(i_rr_ptr) + int'(prefix)) % NUM_UNITS;
                o_slot_map[tgt*IN_PORT_SIZE + k] = 1'b1;
                o_demand[tgt*DW +: DW] = o_demand[tgt*DW +: DW] + DW'(1);
                prefix = prefix + DW'(1);
            end
        end
        o_req_cnt = prefix;
    end

endmodule : scariv_bru_arb_slot_map

// File: rtl/scariv_bru_credit_arbiter.sv
// Credit-based dispatch arbiter sharing branch issue units among a dispatch
// group; the whole group is accepted or stalled atomically.
module scariv_bru_credit_arbiter
    import scariv_pkg::*;
#(
    parameter int NUM_UNITS    = NUM_BRU_UNITS,
    parameter int IN_PORT_SIZE = BRU_DISP_SIZE,
    parameter int MAX_CREDITS  = BRU_ENTRY_SIZE,
    parameter int CW           = $clog2(MAX_CREDITS) + 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [IN_PORT_SIZE-1:0]           i_disp_req,
    input  logic                              i_flush,
    output logic                              o_disp_ready,
    output logic [NUM_UNITS*IN_PORT_SIZE-1:0] o_disp_valid,
    input  logic [NUM_UNITS-1:0]              i_ret_valid,
    input  logic [NUM_UNITS*CW-1:0]           i_ret_val,
    output logic [NUM_UNITS*CW-1:0]           o_credits,
    output logic [31:0]                       o_stall_cycles,
    output logic                              o_error
);

    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DW = $clog2(IN_PORT_SIZE + 1);

    logic [PW-1:0]                     r_rr_ptr;
    logic [CW-1:0]                     r_credits [NUM_UNITS];
    logic [31:0]                       r_stall_cycles;
    logic                              r_error;

    logic [NUM_UNITS*IN_PORT_SIZE-1:0] w_slot_map;
    logic [NUM_UNITS*DW-1:0]           w_demand;
    logic [DW-1:0]                     w_req_cnt;
    logic                              w_has_req;
    logic                              w_credit_ok;
    logic                              w_accepted;
    logic [PW-1:0]                     w_rr_next;
    logic [CW:0]                       w_sum [NUM_UNITS];
    logic [CW-1:0]                     w_credits_next [NUM_UNITS];
    logic [NUM_UNITS-1:0]              w_overflow;

    scariv_bru_arb_slot_map #(
        .NUM_UNITS    (NUM_UNITS),
        .IN_PORT_SIZE (IN_PORT_SIZE),
        .PW           (PW),
        .DW           (DW)
    ) u_slot_map (
        .i_rr_ptr   (r_rr_ptr),
        .i_req      (i_disp_req),
        .o_slot_map (w_slot_map),
        .o_demand   (w_demand),
        .o_req_cnt  (w_req_cnt)
    );

    assign w_has_req = |i_disp_req;

    always_comb begin
        w_credit_ok = 1'b1;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (int'(w_demand[u*DW +: DW]) > int'(r_credits[u])) begin
                w_credit_ok = 1'b0;
            end
        end
    end

    // An empty group is trivially ready; flush overrides everything
    assign o_disp_ready = ~i_flush & (~w_has_req | w_credit_ok);
    assign w_accepted   = o_disp_ready & w_has_req;
    assign o_disp_valid = w_accepted ? w_slot_map : '0;
    assign w_rr_next    = PW'((int'(r_rr_ptr) + int'(w_req_cnt)) % NUM_UNITS);

    // One extra bit of headroom so a return that overshoots MAX_CREDITS is detectable
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_sum[u] = {1'b0, r_credits[u]}
                     - (w_accepted     ? (CW+1)'(w_demand[u*DW +: DW]) : '0)
                     + (i_ret_valid[u] ? {1'b0, i_ret_val[u*CW +: CW]} : '0);
            w_overflow[u]     = w_sum[u] > (CW+1)'(MAX_CREDITS);
            w_credits_next[u] = w_overflow[u] ? CW'(MAX_CREDITS) : w_sum[u][CW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr       <= '0;
            r_stall_cycles <= '0;
            r_error        <= 1'b0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_credits[u] <= CW'(MAX_CREDITS);
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_credits[u] <= w_credits_next[u];
            end
            if (w_accepted) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_has_req & ~i_flush & ~o_disp_ready & (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (|w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_credit_out
        assign o_credits[u*CW +: CW] = r_credits[u];
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_error        = r_error;

endmodule : scariv_bru_credit_arbiter

// File: doc/scariv_bru_credit_arbiter.md
# scariv_bru_credit_arbiter

Dispatch-side arbiter that shares `NUM_UNITS` branch issue units among the branch slots of each dispatch group. It tracks a credit counter per issue unit, mirroring that unit's free scheduler entries. It steers each valid slot to a unit in round-robin order and accepts or stalls the whole group atomically. It sits between the rename/dispatch stage and the branch issue units, and consumes their per-unit credit-return strobes.

## Interface
Parameters:
- `NUM_UNITS`, 2, number of branch issue units sharing dispatch; power of two, at least 1
- `IN_PORT_SIZE`, 2, branch slots per dispatch group
- `MAX_CREDITS`, 32, entries per issue unit (ENTRY_SIZE of each unit)
- `CW`, `$clog2(MAX_CREDITS)+1`, credit counter width (derived)

Ports:
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset; **one clock; reset is synchronous and active-high**
- `i_disp_req`  in  IN_PORT_SIZE  valid branch slot in current dispatch group
- `i_flush`  in  1  commit flush; the current group is discarded
- `o_disp_ready`  out  1  group accepted this cycle
- `o_disp_valid`  out  NUM_UNITS*IN_PORT_SIZE  bit [u*IN_PORT_SIZE+k] = slot k sent to unit u
- `i_ret_valid`  in  NUM_UNITS  credit-return strobe per unit
- `i_ret_val`  in  NUM_UNITS*CW  credits returned per unit (field u)
- `o_credits`  out  NUM_UNITS*CW  registered credit count per unit
- `o_stall_cycles`  out  32  saturating count of stalled request cycles
- `o_error`  out  1  sticky credit-overflow flag

## Operation
- Slot order: the k-th set bit of `i_disp_req` (k = 0..popcount-1, counted from LSB) targets unit `(r_rr_ptr + k) mod NUM_UNITS`.
- Demand: `demand[u]` is the number of slots targeting u.
- Accept condition: `|i_disp_req & ~i_flush & (demand[u] <= r_credits[u] for all u)`.
- On accept:
  - `o_disp_ready=1`.
  - `o_disp_valid` shows the mapping.
  - `r_rr_ptr <= (r_rr_ptr + popcount(i_disp_req)) mod NUM_UNITS`.
- On reject:
  - `o_disp_ready=0` and `o_disp_valid=0`.
  - No credit is consumed and `r_rr_ptr` is unchanged.
  - The group is never split.
- Empty group: `o_disp_ready=1`, `o_disp_valid=0`, no state change.
- Flush:
  - Forces `o_disp_ready=0` and `o_disp_valid=0`; nothing is consumed.
  - Credit returns are still applied.
  - `r_rr_ptr` is unchanged.
  - The stall counter does not count this cycle.
- Credit update, per unit: `r_credits[u] <= r_credits[u] - (accepted ? demand[u] : 0) + (i_ret_valid[u] ? ret_val[u] : 0)`.
  - Compute at CW+1 bits.
  - If the result exceeds `MAX_CREDITS`, clip to `MAX_CREDITS` and set `o_error` (sticky until reset).
- Stall counter: increments when `|i_disp_req & ~i_flush & ~o_disp_ready`; saturates at 0xFFFF_FFFF.

## Timing
- Reset values:
  - `r_credits[u] = MAX_CREDITS`, so `o_credits` reads all-MAX.
  - `r_rr_ptr = 0`, `o_error = 0`, `o_stall_cycles = 0`.
  - `o_disp_ready` and `o_disp_valid` are combinational and evaluate on the reset state.
- `o_disp_ready` and `o_disp_valid` are combinational from `i_disp_req`, `i_flush` and registered state; zero-cycle decision.
- A return on cycle N is visible in `o_credits` and the accept check from cycle N+1. Same-cycle returns do not unblock cycle N.
- A consume on cycle N reduces credits from N+1.
- Consume and return on the same unit in the same cycle net correctly; no priority between them.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - Outstanding issue-unit entries are not tracked; issue units must be reset together with this block.
- The accept check compares against the full counter (no off-by-one). Credits = 0 blocks any group with `demand[u] >= 1`.

## Structure
- `scariv_pkg` holds:
  - `bru_arb_credit_t` (`logic [CW-1:0]`)
  - the `NUM_BRU_UNITS` constant, sourced from `scariv_conf_pkg`
- One sub-module, `scariv_bru_arb_slot_map`: combinational mapping of the rr pointer plus the request vector to the per-unit one-hot slot matrix and `demand[u]`, using `bit_cnt`-style prefix counts.
- Top level holds:
  - the credit registers, rr pointer, stall counter and error flag
  - the accept logic

## Test plan
- Reset, then `i_disp_req=2'b11` with NUM_UNITS=2 → ready=1, slot0→unit0, slot1→unit1, credits 31/31, rr_ptr stays 0.
- `i_disp_req=2'b01` three times → units 0,1,0 in turn; credits 30/31 after the three groups (starting from 32/32 after reset).
- Drain unit1 to 0 credits, then `i_disp_req=2'b11` → ready=0, valid=0, stall_cycles+1. Return 1 to unit1 → accepted on the next cycle, not the same cycle.
- Same cycle: accept consumes 1 on unit0 and `i_ret_valid[0]` with val 1 → unit0 credit unchanged.
- `i_flush=1` with `i_disp_req=2'b11` and `i_ret_valid[1]`=2 → valid=0, no consume, unit1 +2, stall counter unchanged.
- Return 1 to unit0 at `MAX_CREDITS` → credit stays 32, `o_error=1` sticky. Assert `i_reset` → all outputs return to reset values next cycle.
